// File: rtl/padd_issue.sv
// padd_issue: operand issue and in-order result collection around the PAdder pipelined 32-bit adder.
// Latency: LATENCY+1 edges from accept to Out_Valid. Sustained throughput is 1 op/cycle while Out_Ready=1.
// Backpressure: In_Ready is a credit check (FIFO entries + ops in flight < DEPTH), so a stalled consumer never loses a result.
// Ports: Clock/Reset_N (async active-low); In_* operand handshake; Add_* registered operands to and raw results from the adder;
//        Out_* result FIFO head with valid/ready; Op_Count counts FIFO pushes and wraps at 16 bits.
module padd_issue #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 8
) (
   input  logic        Clock,
   input  logic        Reset_N,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic [31:0] In_A,
   input  logic [31:0] In_B,
   input  logic        In_CI,
   output logic [31:0] Add_A,
   output logic [31:0] Add_B,
   output logic        Add_CI,
   input  logic [31:0] Add_S,
   input  logic        Add_CO,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [31:0] Out_Sum,
   output logic        Out_CO,
   output logic        Out_Ovf,
   output logic [15:0] Op_Count
);

   localparam int AW = $clog2(DEPTH);
   // Wide enough for DEPTH FIFO entries plus LATENCY+1 in-flight tags.
   localparam int CW = $clog2(DEPTH + LATENCY + 2);

   typedef struct packed {
      logic [31:0] sum;
      logic        co;
      logic        ovf;
   } res_t;

   logic accept;
   assign accept = In_Valid && In_Ready;

   // Adder operand registers: idle cycles feed zeros so the adder sees a quiet input.
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         Add_A  <= '0;
         Add_B  <= '0;
         Add_CI <= 1'b0;
      end else if (accept) begin
         Add_A  <= In_A;
         Add_B  <= In_B;
         Add_CI <= In_CI;
      end else begin
         Add_A  <= '0;
         Add_B  <= '0;
         Add_CI <= 1'b0;
      end
   end

   // Tag stage 0 sits alongside the Add_* registers; stage LATENCY is the cycle in which
   // Add_S/Add_CO belong to that op. The adder cannot stall, so neither does this pipe.
   logic [LATENCY:0] tag_vld;
   logic [LATENCY:0] tag_a31;
   logic [LATENCY:0] tag_b31;

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         tag_vld <= '0;
         tag_a31 <= '0;
         tag_b31 <= '0;
      end else begin
         tag_vld <= {tag_vld[LATENCY-1:0], accept};
         tag_a31 <= {tag_a31[LATENCY-1:0], In_A[31]};
         tag_b31 <= {tag_b31[LATENCY-1:0], In_B[31]};
      end
   end

   logic push;
   logic pop;
   logic full;
   logic empty;
   res_t wr_res;
   res_t head;

   assign push       = tag_vld[LATENCY];
   assign wr_res.sum = Add_S;
   assign wr_res.co  = Add_CO;
   // Signed overflow: operands agree in sign but the sum does not.
   assign wr_res.ovf = (tag_a31[LATENCY] == tag_b31[LATENCY]) && (Add_S[31] != tag_a31[LATENCY]);

   // Result FIFO; pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [AW:0] fifo_count;
   res_t        mem [DEPTH];

   assign fifo_count = wr_ptr - rd_ptr;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = !empty && Out_Ready;

   // Storage needs no reset: nothing is read from it until a push has filled the slot.
   always_ff @(posedge Clock) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= wr_res;
      end
   end

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         Op_Count <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            Op_Count <= Op_Count + 16'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Head is masked while empty so stale or never-written slots do not leak onto Out_*.
   assign head      = mem[rd_ptr[AW-1:0]];
   assign Out_Valid = !empty;
   assign Out_Sum   = empty ? 32'd0 : head.sum;
   assign Out_CO    = empty ? 1'b0  : head.co;
   assign Out_Ovf   = empty ? 1'b0  : head.ovf;

   // Every op still in the pipe already owns a FIFO slot; count them against DEPTH.
   logic [CW-1:0] inflight;
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= LATENCY; i++) begin
         inflight = inflight + CW'(tag_vld[i]);
      end
   end

   assign In_Ready = (CW'(fifo_count) + inflight) < CW'(DEPTH);

   // The credit check makes this unreachable; firing means the credit accounting is broken.
   assert property (@(posedge Clock) disable iff (!Reset_N) !(push && full && !pop));

endmodule

// File: tb/tb_padd_issue.sv
module tb_padd_issue;

   logic        Clock = 1'b0;
   logic        Reset_N = 1'b0;
   logic        In_Valid = 1'b0;
   logic        In_Ready;
   logic [31:0] In_A = '0;
   logic [31:0] In_B = '0;
   logic        In_CI = 1'b0;
   logic [31:0] Add_A;
   logic [31:0] Add_B;
   logic        Add_CI;
   logic [31:0] Add_S;
   logic        Add_CO;
   logic        Out_Valid;
   logic        Out_Ready = 1'b0;
   logic [31:0] Out_Sum;
   logic        Out_CO;
   logic        Out_Ovf;
   logic [15:0] Op_Count;

   always #5 Clock = ~Clock;

   padd_issue #(.LATENCY(4), .DEPTH(8)) dut (
      .Clock(Clock), .Reset_N(Reset_N),
      .In_Valid(In_Valid), .In_Ready(In_Ready),
      .In_A(In_A), .In_B(In_B), .In_CI(In_CI),
      .Add_A(Add_A), .Add_B(Add_B), .Add_CI(Add_CI),
      .Add_S(Add_S), .Add_CO(Add_CO),
      .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
      .Out_Sum(Out_Sum), .Out_CO(Out_CO), .Out_Ovf(Out_Ovf),
      .Op_Count(Op_Count)
   );

   // Behavioural PAdder: four unreset register stages, result 4 cycles after the operands.
   logic [32:0] adder_pipe [4];
   always @(posedge Clock) begin
      adder_pipe[0] <= {1'b0, Add_A} + {1'b0, Add_B} + {32'd0, Add_CI};
      for (int i = 1; i < 4; i++) adder_pipe[i] <= adder_pipe[i-1];
   end
   assign {Add_CO, Add_S} = adder_pipe[3];

   // Reference model: every accepted op not yet popped, with the edge at which it becomes visible.
   typedef struct {
      logic [31:0] s;
      logic        co;
      logic        ovf;
      int          t;
   } mres_t;

   mres_t       exp_q[$];
   int          cyc = 0;
   logic [15:0] exp_cnt = '0;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;
   logic        exp_ci = 1'b0;
   int          compared = 0;
   int          mismatched = 0;

   function automatic mres_t ref_add(logic [31:0] a, logic [31:0] b, logic ci);
      mres_t  r;
      logic [32:0] w;
      longint sv;
      w  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      sv = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
      r.s   = w[31:0];
      r.co  = w[32];
      r.ovf = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      r.t   = 0;
      return r;
   endfunction

   function automatic bit exp_valid();
      return (exp_q.size() > 0) && (exp_q[0].t <= cyc);
   endfunction

   function automatic logic [116:0] got_vec(bit ev);
      return {In_Ready, Out_Valid, Op_Count, ev ? {Out_Sum, Out_CO, Out_Ovf} : 34'd0,
              Add_A, Add_B, Add_CI};
   endfunction

   function automatic logic [116:0] exp_vec(bit ev);
      logic [33:0] d;
      d = ev ? {exp_q[0].s, exp_q[0].co, exp_q[0].ovf} : 34'd0;
      return {exp_q.size() < 8, ev, exp_cnt, d, exp_a, exp_b, exp_ci};
   endfunction

   task automatic set_rand();
      int pick;
      pick = $urandom_range(0, 7);
      case (pick)
         0:       begin In_A = 32'h7FFF_FFFF; In_B = $urandom_range(0, 3); end
         1:       begin In_A = 32'h8000_0000; In_B = 32'h8000_0000 | $urandom; end
         2:       begin In_A = 32'hFFFF_FFFF; In_B = $urandom; end
         default: begin In_A = $urandom; In_B = $urandom; end
      endcase
      In_CI = 1'($urandom_range(0, 1));
   endtask

   // Advance one edge, updating the model from the handshake the model itself predicts.
   task automatic step();
      bit    acc;
      bit    pop;
      mres_t r;
      acc = In_Valid && (exp_q.size() < 8);
      pop = Out_Ready && exp_valid();
      @(posedge Clock);
      cyc++;
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
         r = ref_add(In_A, In_B, In_CI);
         r.t = cyc + 5;
         exp_q.push_back(r);
         exp_a = In_A; exp_b = In_B; exp_ci = In_CI;
      end else begin
         exp_a = '0; exp_b = '0; exp_ci = 1'b0;
      end
      foreach (exp_q[i]) if (exp_q[i].t == cyc) exp_cnt++;
      #1;
   endtask

   task automatic test_reset();
      logic [116:0] want;
      Reset_N = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      want = {1'b1, 1'b0, 16'd0, 34'd0, 32'd0, 32'd0, 1'b0};
      if ({In_Ready, Out_Valid, Op_Count, Out_Sum, Out_CO, Out_Ovf, Add_A, Add_B, Add_CI} !== want) begin
         mismatched++;
         $display("FAIL reset_state got=%h want=%h",
                  {In_Ready, Out_Valid, Op_Count, Out_Sum, Out_CO, Out_Ovf, Add_A, Add_B, Add_CI}, want);
      end
      compared++;
      Reset_N = 1'b1;
      step();
      if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
         mismatched++;
         $display("FAIL reset_release got=%h exp=%h", got_vec(exp_valid()), exp_vec(exp_valid()));
      end
      compared++;
   endtask

   task automatic test_single();
      Out_Ready = 1'b0;
      In_Valid = 1'b1; In_A = 32'hFFFF_FFFF; In_B = 32'd1; In_CI = 1'b0;
      step();
      In_Valid = 1'b0;
      for (int n = 0; n < 4; n++) begin
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL single_fill n=%0d got=%h exp=%h", n, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      step();
      if ({Out_Valid, Out_Sum, Out_CO, Out_Ovf, Op_Count} !== {1'b1, 32'd0, 1'b1, 1'b0, 16'd1}) begin
         mismatched++;
         $display("FAIL single_result got v=%b s=%h co=%b ovf=%b cnt=%0d want v=1 s=0 co=1 ovf=0 cnt=1",
                  Out_Valid, Out_Sum, Out_CO, Out_Ovf, Op_Count);
      end
      compared++;
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0;
      if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
         mismatched++;
         $display("FAIL single_pop got=%h exp=%h", got_vec(exp_valid()), exp_vec(exp_valid()));
      end
      compared++;
   endtask

   task automatic test_overflow();
      Out_Ready = 1'b1;
      In_Valid = 1'b1; In_A = 32'h7FFF_FFFF; In_B = 32'd1; In_CI = 1'b0;
      step();
      In_A = 32'h8000_0000; In_B = 32'h8000_0000; In_CI = 1'b0;
      step();
      In_Valid = 1'b0;
      for (int n = 0; n < 7; n++) begin
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL ovf_model n=%0d got=%h exp=%h", n, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
         if (n == 3) begin
            if ({Out_Valid, Out_Sum, Out_CO, Out_Ovf} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1}) begin
               mismatched++;
               $display("FAIL ovf_pos got v=%b s=%h co=%b ovf=%b want v=1 s=80000000 co=0 ovf=1",
                        Out_Valid, Out_Sum, Out_CO, Out_Ovf);
            end
            compared++;
         end
         if (n == 4) begin
            if ({Out_Valid, Out_Sum, Out_CO, Out_Ovf, Op_Count} !== {1'b1, 32'd0, 1'b1, 1'b1, 16'd3}) begin
               mismatched++;
               $display("FAIL ovf_neg got v=%b s=%h co=%b ovf=%b cnt=%0d want v=1 s=0 co=1 ovf=1 cnt=3",
                        Out_Valid, Out_Sum, Out_CO, Out_Ovf, Op_Count);
            end
            compared++;
         end
      end
   endtask

   task automatic test_stream();
      logic [15:0] start_cnt;
      int          n;
      start_cnt = exp_cnt;
      Out_Ready = 1'b1;
      In_Valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         set_rand();
         if (In_Ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stream_rdy i=%0d got=%b want=1", i, In_Ready);
         end
         compared++;
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL stream i=%0d got=%h exp=%h", i, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      In_Valid = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         step();
         n++;
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL stream_drain n=%0d got=%h exp=%h", n, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      if (Op_Count !== start_cnt + 16'd100) begin
         mismatched++;
         $display("FAIL stream_count got=%0d want=%0d", Op_Count, start_cnt + 16'd100);
      end
      compared++;
   endtask

   task automatic test_backpressure();
      int n_acc;
      Out_Ready = 1'b0;
      In_Valid = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 20; i++) begin
         set_rand();
         if (In_Valid && In_Ready) n_acc++;
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL bp_fill i=%0d got=%h exp=%h", i, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      if (n_acc != 8) begin
         mismatched++;
         $display("FAIL bp_accepts got=%0d want=8", n_acc);
      end
      compared++;
      if ({In_Ready, Out_Valid} !== 2'b01) begin
         mismatched++;
         $display("FAIL bp_full got rdy=%b vld=%b want rdy=0 vld=1", In_Ready, Out_Valid);
      end
      compared++;
      Out_Ready = 1'b1;
      step();
      Out_Ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         set_rand();
         if (In_Valid && In_Ready) n_acc++;
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL bp_refill i=%0d got=%h exp=%h", i, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      if (n_acc != 1) begin
         mismatched++;
         $display("FAIL bp_one_credit got=%0d want=1", n_acc);
      end
      compared++;
   endtask

   task automatic test_full_drain();
      int n;
      In_Valid = 1'b1;
      Out_Ready = 1'b1;
      for (int i = 0; i < 55; i++) begin
         set_rand();
         if (i >= 15) begin
            In_Valid  = 1'($urandom_range(0, 1));
            Out_Ready = 1'($urandom_range(0, 1));
         end
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL full_flow i=%0d got=%h exp=%h", i, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      In_Valid = 1'b0;
      Out_Ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 30) begin
         step();
         n++;
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL full_drain n=%0d got=%h exp=%h", n, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      if (Out_Valid !== 1'b0) begin
         mismatched++;
         $display("FAIL full_empty got vld=%b want 0", Out_Valid);
      end
      compared++;
   endtask

   task automatic test_reset_midflight();
      Out_Ready = 1'b1;
      In_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_rand();
         step();
      end
      In_Valid = 1'b0;
      step();
      step();
      #2;
      Reset_N = 1'b0;
      #1;
      if ({Out_Valid, Op_Count, In_Ready, Add_A} !== {1'b0, 16'd0, 1'b1, 32'd0}) begin
         mismatched++;
         $display("FAIL rst_async got vld=%b cnt=%0d rdy=%b adda=%h want 0/0/1/0",
                  Out_Valid, Op_Count, In_Ready, Add_A);
      end
      compared++;
      exp_q.delete();
      exp_cnt = '0;
      exp_a = '0; exp_b = '0; exp_ci = 1'b0;
      @(posedge Clock);
      cyc++;
      #1;
      Reset_N = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL rst_quiet i=%0d got=%h exp=%h", i, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      In_Valid = 1'b1; In_A = 32'h1234_5678; In_B = 32'h1111_1111; In_CI = 1'b1;
      Out_Ready = 1'b0;
      step();
      In_Valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (got_vec(exp_valid()) !== exp_vec(exp_valid())) begin
            mismatched++;
            $display("FAIL rst_newop i=%0d got=%h exp=%h", i, got_vec(exp_valid()), exp_vec(exp_valid()));
         end
         compared++;
      end
      if ({Out_Valid, Out_Sum, Out_CO, Out_Ovf, Op_Count} !== {1'b1, 32'h2345_678A, 1'b0, 1'b0, 16'd1}) begin
         mismatched++;
         $display("FAIL rst_newop_result got v=%b s=%h co=%b ovf=%b cnt=%0d want v=1 s=2345678a co=0 ovf=0 cnt=1",
                  Out_Valid, Out_Sum, Out_CO, Out_Ovf, Op_Count);
      end
      compared++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_stream();
      test_backpressure();
      test_full_drain();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
